// File: rtl/fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer
//
// Control sequencer for a time-multiplexed FIR filter. For each input sample
// it writes the sample into a circular sample RAM. It then walks all taps
// through an external multiply-accumulate unit, waits for the MAC pipeline to
// drain, and presents the filtered result to the serializer with a
// valid/ready handshake.
//
// Sequence for one sample (cycle 0 is the accept edge):
//   WRITE  (cycle 1)                    : o_wr_en pulse at o_wr_addr = wr_ptr
//   MAC    (cycles 2 .. FIR_DEPTH+1)    : tap k = 0 .. FIR_DEPTH-1
//   DRAIN  (MAC_LATENCY cycles)         : wait for the MAC pipeline
//   OUTPUT (from FIR_DEPTH+2+MAC_LATENCY): o_result_valid until i_result_ready
//
// Parameters
//   DATA_WIDTH  : sample width of the datapath. Only parameter-checked here.
//   FIR_DEPTH   : number of taps, 2..256 (a power of two is not required).
//   MAC_LATENCY : pipeline depth of the external MAC, in cycles (0 allowed).
//
// Ports
//   i_clk, i_rst_n      : clock and asynchronous active-low reset
//   i_en                : global enable; when low, all progress is frozen
//   i_sample_valid      : a deserialized sample word is available
//   o_sample_ready      : the sequencer can accept a sample (IDLE and enabled)
//   o_wr_en, o_wr_addr  : sample RAM write strobe and address (= wr_ptr)
//   o_rd_addr           : sample RAM read address, (wr_ptr - k) mod FIR_DEPTH
//   o_coef_addr         : coefficient ROM address (= k)
//   o_acc_clr           : MAC loads the product instead of accumulating (k=0)
//   o_acc_en            : MAC accumulate enable
//   o_result_valid      : filtered word ready; i_result_ready completes it
//   o_busy              : high in every state except IDLE
//
// Optional feature (compile-time macro FIR_SEQ_OVERRUN_CNT_EN)
//   o_overrun_cnt [7:0] : saturating count of cycles with i_en=1,
//                         i_sample_valid=1 and o_sample_ready=0.
// ---------------------------------------------------------------------------
module fir_mac_sequencer #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIR_DEPTH   = 48,
  parameter int MAC_LATENCY = 2,
  localparam int ADDR_WIDTH = $clog2(FIR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_sample_valid,
  output logic                  o_sample_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_coef_addr,
  output logic                  o_acc_clr,
  output logic                  o_acc_en,
  output logic                  o_result_valid,
  input  logic                  i_result_ready,
  output logic                  o_busy
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]            o_overrun_cnt
`endif
);

  // The drain counter only has to hold MAC_LATENCY-1; keep it at least one bit
  // wide so MAC_LATENCY of 0 or 1 still elaborates.
  localparam int DCW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [DCW-1:0] DRAIN_INIT =
    DCW'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(FIR_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(FIR_DEPTH);

  // Reject parameter sets the sequencer is not built for.
  if (FIR_DEPTH < 2 || FIR_DEPTH > 256 || MAC_LATENCY < 0 || DATA_WIDTH < 1)
  begin : g_bad_params
    $error("fir_mac_sequencer: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_MAC,
    ST_DRAIN,
    ST_OUTPUT
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   k_q, k_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DCW-1:0]          drain_q, drain_d;
  logic [ADDR_WIDTH-1:0]   rd_mac;

  // Next-state logic. Nothing advances while i_en is low, which freezes the
  // state, the tap counter, the write pointer and the drain counter together.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wr_ptr_d = wr_ptr_q;
    drain_d  = drain_q;
    if (i_en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_sample_valid) begin
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          state_d = ST_MAC;
          k_d     = '0;
        end
        ST_MAC: begin
          if (k_q == LAST_IDX) begin
            k_d = '0;
            // With no MAC pipeline there is nothing to wait for.
            if (MAC_LATENCY == 0) begin
              state_d = ST_OUTPUT;
            end else begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_INIT;
            end
          end else begin
            k_d = k_q + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_d = ST_OUTPUT;
          end else begin
            drain_d = drain_q - DCW'(1);
          end
        end
        ST_OUTPUT: begin
          // A sample offered in this cycle is not taken: ready is only
          // decoded in IDLE, so it is accepted in the following cycle.
          if (i_result_ready) begin
            state_d  = ST_IDLE;
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      wr_ptr_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      drain_q  <= drain_d;
    end
  end

  // Newest sample sits at wr_ptr, and tap k reads the sample k steps older.
  // The subtraction borrows FIR_DEPTH explicitly, so depths that are not a
  // power of two wrap correctly (wr_ptr=0, k=1 -> FIR_DEPTH-1).
  always_comb begin
    if (k_q > wr_ptr_q) begin
      rd_mac = ADDR_WIDTH'({1'b0, wr_ptr_q} + DEPTH_EXT - {1'b0, k_q});
    end else begin
      rd_mac = wr_ptr_q - k_q;
    end
  end

  // Outputs are decoded from the state registers. Strobes are gated by i_en
  // so a freeze silences the RAM and MAC. o_result_valid is deliberately not
  // gated, so the result stays visible while frozen. o_sample_ready is also
  // gated by reset so that every output reads 0 while reset is held.
  always_comb begin
    o_sample_ready = i_rst_n & i_en & (state_q == ST_IDLE);
    o_wr_en        = i_en & (state_q == ST_WRITE);
    o_wr_addr      = wr_ptr_q;
    o_rd_addr      = '0;
    o_coef_addr    = '0;
    o_acc_en       = 1'b0;
    o_acc_clr      = 1'b0;
    if (state_q == ST_MAC) begin
      o_rd_addr   = rd_mac;
      o_coef_addr = k_q;
      o_acc_en    = i_en;
      o_acc_clr   = i_en & (k_q == '0);
    end
    o_result_valid = (state_q == ST_OUTPUT);
    o_busy         = (state_q != ST_IDLE);
  end

`ifdef FIR_SEQ_OVERRUN_CNT_EN
  logic [7:0] overrun_q, overrun_d;

  // Counts cycles in which an enabled upstream offers a sample that cannot be
  // taken. The count saturates rather than wrapping.
  always_comb begin
    overrun_d = overrun_q;
    if (i_en && i_sample_valid && !o_sample_ready && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign o_overrun_cnt = overrun_q;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_sequencer
//
// Self-checking bench for fir_mac_sequencer at its default parameters. The
// behavioural model tracks each sample as "busy + position in its timeline +
// write pointer". Every output is derived from that description on each
// falling edge. Directed scenarios pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_fir_mac_sequencer;

  localparam int FD      = 48;
  localparam int ML      = 2;
  localparam int AW      = $clog2(FD);
  localparam int OUT_POS = FD + 2 + ML;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_en;
  logic          i_sample_valid;
  logic          o_sample_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [AW-1:0] o_rd_addr;
  logic [AW-1:0] o_coef_addr;
  logic          o_acc_clr;
  logic          o_acc_en;
  logic          o_result_valid;
  logic          i_result_ready;
  logic          o_busy;
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  logic [7:0]    o_overrun_cnt;
`endif

  fir_mac_sequencer #(
    .DATA_WIDTH (24),
    .FIR_DEPTH  (FD),
    .MAC_LATENCY(ML)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready),
    .o_wr_en       (o_wr_en),
    .o_wr_addr     (o_wr_addr),
    .o_rd_addr     (o_rd_addr),
    .o_coef_addr   (o_coef_addr),
    .o_acc_clr     (o_acc_clr),
    .o_acc_en      (o_acc_en),
    .o_result_valid(o_result_valid),
    .i_result_ready(i_result_ready),
    .o_busy        (o_busy)
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    ,
    .o_overrun_cnt (o_overrun_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Model state: one sample in flight at most.
  bit m_busy = 1'b0;
  int m_pos  = 0;
  int m_wptr = 0;
  int m_ovr  = 0;

  // Monitor records
  int wr_log[$];
  int rd_k1_w0 = -1;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dutVec();
    return 64'({o_sample_ready, o_wr_en, o_wr_addr, o_rd_addr, o_coef_addr,
                o_acc_clr, o_acc_en, o_result_valid, o_busy});
  endfunction

  // Expected outputs from the timeline position: 1 = write, 2..FD+1 = tap
  // pos-2, then ML drain cycles, then the result waits at OUT_POS.
  function automatic logic [63:0] modelVec();
    bit            mac;
    int            k;
    logic [AW-1:0] rd;
    logic [AW-1:0] cf;
    mac = m_busy && (m_pos >= 2) && (m_pos <= FD + 1);
    k   = m_pos - 2;
    rd  = mac ? AW'((m_wptr - k + FD) % FD) : '0;
    cf  = mac ? AW'(k) : '0;
    return 64'({(!m_busy && i_en && i_rst_n), (m_busy && m_pos == 1 && i_en),
                AW'(m_wptr), rd, cf, (mac && i_en && k == 0), (mac && i_en),
                (m_busy && m_pos == OUT_POS), m_busy});
  endfunction

  // Model update on each rising edge; reset clears it asynchronously.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_busy = 1'b0;
      m_pos  = 0;
      m_wptr = 0;
      m_ovr  = 0;
    end else if (i_en) begin
      if (i_sample_valid && m_busy && m_ovr < 255) m_ovr++;
      if (!m_busy) begin
        if (i_sample_valid) begin
          m_busy = 1'b1;
          m_pos  = 1;
        end
      end else if (m_pos < OUT_POS) begin
        m_pos++;
      end else if (i_result_ready) begin
        m_busy = 1'b0;
        m_wptr = (m_wptr + 1) % FD;
      end
    end
  end

  // The single compare process: all outputs against the model every cycle.
  initial begin
    forever begin
      @(negedge i_clk);
      checkOutput("outputs", dutVec(), modelVec());
`ifdef FIR_SEQ_OVERRUN_CNT_EN
      checkOutput("overrun_cnt", 64'(o_overrun_cnt), 64'(m_ovr));
`endif
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_wr_en) wr_log.push_back(int'(o_wr_addr));
      if (o_acc_en && o_coef_addr == AW'(1) && o_wr_addr == '0)
        rd_k1_w0 = int'(o_rd_addr);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d",
             checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic valid,
                               input logic ready);
    i_en           = en;
    i_sample_valid = valid;
    i_result_ready = ready;
  endtask

  task automatic doReset();
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    tick();
  endtask

  task automatic acceptSample(output int a);
    i_sample_valid = 1'b1;
    tick();
    a = cyc;
    i_sample_valid = 1'b0;
  endtask

  // Waits (bounded) until a falling edge where the condition holds; returns at
  // that falling edge. what=0: result valid; what=1: MAC on tap val.
  task automatic waitNeg(input int what, input int val, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge i_clk);
      if (what == 0) begin
        if (o_result_valid === 1'b1) begin
          found = 1'b1;
          break;
        end
      end else if (o_acc_en === 1'b1 && o_coef_addr == AW'(val)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput({name, "_reached"}, 64'(found), 64'(1));
  endtask

  initial begin
    int a;
    int n;
    int wr_cnt, wr_cyc, wr_adr, acc_first, acc_last, acc_cnt, clr_cnt, clr_cyc;
    int rv_first, held, froze, bad, guard;

    i_rst_n = 1'b0;
    applyStimulus(0, 0, 0);
    #2;
    checkOutput("reset_state", dutVec(), 64'(0));
    #21 i_rst_n = 1'b1;
    tick();
    checkOutput("idle_disabled_ready", 64'(o_sample_ready), 64'(0));

    // One sample with immediate result acceptance; record the timeline.
    $display("[TB] single sample timeline");
    applyStimulus(1, 0, 1);
    tick();
    acceptSample(a);
    wr_cnt = 0; wr_cyc = -1; wr_adr = -1; acc_first = -1; acc_last = -1;
    acc_cnt = 0; clr_cnt = 0; clr_cyc = -1; rv_first = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clk);
      n = cyc - a + 1;
      if (o_wr_en) begin wr_cnt++; wr_cyc = n; wr_adr = int'(o_wr_addr); end
      if (o_acc_en) begin
        if (acc_first < 0) acc_first = n;
        acc_last = n;
        acc_cnt++;
      end
      if (o_acc_clr) begin clr_cnt++; clr_cyc = n; end
      if (o_result_valid && rv_first < 0) rv_first = n;
      tick();
    end
    checkOutput("wr_en_count", 64'(wr_cnt), 64'(1));
    checkOutput("wr_en_cycle", 64'(wr_cyc), 64'(1));
    checkOutput("wr_en_addr", 64'(wr_adr), 64'(0));
    checkOutput("acc_en_first", 64'(acc_first), 64'(2));
    checkOutput("acc_en_last", 64'(acc_last), 64'(49));
    checkOutput("acc_en_count", 64'(acc_cnt), 64'(48));
    checkOutput("acc_clr_count", 64'(clr_cnt), 64'(1));
    checkOutput("acc_clr_cycle", 64'(clr_cyc), 64'(2));
    checkOutput("result_valid_cycle", 64'(rv_first), 64'(52));

    // 49 samples with random gaps: write pointer walks 0..47 and wraps to 0.
    $display("[TB] write pointer wrap");
    doReset();
    wr_log.delete();
    rd_k1_w0 = -1;
    guard = 0;
    while (wr_log.size() < 49 && guard < 4000) begin
      applyStimulus(1, ($urandom_range(0, 99) < 70), 1);
      tick();
      guard++;
    end
    applyStimulus(1, 0, 1);
    repeat (60) tick();
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != i % FD) bad++;
    checkOutput("wr_ptr_count", 64'(wr_log.size()), 64'(49));
    checkOutput("wr_ptr_sequence_bad", 64'(bad), 64'(0));
    checkOutput("wr_ptr_wrap_to_0",
                64'((wr_log.size() == 49) ? wr_log[48] : -1), 64'(0));
    checkOutput("rd_addr_wptr0_k1", 64'(rd_k1_w0), 64'(47));

    // Result held back for 10 cycles, then next sample one cycle after.
    $display("[TB] result backpressure");
    applyStimulus(1, 0, 0);
    acceptSample(a);
    waitNeg(0, 0, "bp_result");
    i_sample_valid = 1'b1;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge i_clk);
      if (o_result_valid && o_busy && !o_sample_ready) held++;
      tick();
    end
    checkOutput("bp_held_cycles", 64'(held), 64'(10));
    i_result_ready = 1'b1;
    @(negedge i_clk);
    checkOutput("bp_still_valid", 64'(o_result_valid), 64'(1));
    tick();
    @(negedge i_clk);
    checkOutput("bp_ready_after_handshake", 64'(o_sample_ready), 64'(1));
    tick();
    i_sample_valid = 1'b0;
    @(negedge i_clk);
    checkOutput("bp_next_accept_write", 64'(o_wr_en), 64'(1));
    tick();
    waitNeg(0, 0, "bp_second_result");
    tick();

    // Freeze for 5 cycles with the tap counter at 20.
    $display("[TB] enable freeze");
    doReset();
    applyStimulus(1, 0, 1);
    acceptSample(a);
    waitNeg(1, 19, "freeze_k19");
    tick();
    i_en = 1'b0;
    froze = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (o_coef_addr == AW'(20) && !o_acc_en && o_busy && !o_sample_ready)
        froze++;
      tick();
    end
    checkOutput("freeze_hold_k20", 64'(froze), 64'(5));
    i_en = 1'b1;
    @(negedge i_clk);
    checkOutput("resume_coef_addr", 64'(o_coef_addr), 64'(20));
    checkOutput("resume_acc_en", 64'(o_acc_en), 64'(1));
    tick();
    waitNeg(0, 0, "freeze_result");
    checkOutput("freeze_result_cycle", 64'(cyc - a + 1), 64'(57));
    tick();

    // Asynchronous reset in the middle of the tap loop.
    $display("[TB] reset mid-MAC");
    doReset();
    applyStimulus(1, 0, 1);
    acceptSample(a);
    waitNeg(0, 0, "pre_reset_result");
    tick();
    acceptSample(a);
    waitNeg(1, 30, "reset_k30");
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("reset_async_outputs", dutVec(), 64'(0));
    tick();
    tick();
    #2 i_rst_n = 1'b1;
    tick();
    checkOutput("post_reset_ready", 64'(o_sample_ready), 64'(1));
    checkOutput("post_reset_busy", 64'(o_busy), 64'(0));
    acceptSample(a);
    @(negedge i_clk);
    checkOutput("post_reset_wr_en", 64'(o_wr_en), 64'(1));
    checkOutput("post_reset_wr_addr", 64'(o_wr_addr), 64'(0));
    tick();
    waitNeg(0, 0, "post_reset_result");
    checkOutput("post_reset_result_wptr", 64'(o_wr_addr), 64'(0));
    tick();

    // Random soak against the model.
    $display("[TB] random soak");
    doReset();
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(($urandom_range(0, 99) < 90), ($urandom_range(0, 99) < 50),
                    ($urandom_range(0, 99) < 40));
      tick();
    end

`ifdef FIR_SEQ_OVERRUN_CNT_EN
    $display("[TB] overrun counter saturation");
    doReset();
    applyStimulus(1, 1, 0);
    repeat (320) tick();
    @(negedge i_clk);
    checkOutput("overrun_saturated", 64'(o_overrun_cnt), 64'(255));
    tick();
`endif

    applyStimulus(1, 0, 1);
    repeat (70) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
